// File: rtl/fp_addsub_pipe_if.sv
// Operand/result handshake bundle for the pipelined FP adder/subtractor.
// master drives operands and out_ready; slave is the arithmetic unit.
interface fp_addsub_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic         op_sub;
  logic [W-1:0] opr1;
  logic [W-1:0] opr2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] res;
  logic [3:0]   flags;

  modport master (output in_valid, op_sub, opr1, opr2, out_ready,
                  input  in_ready, out_valid, res, flags);
  modport slave  (input  in_valid, op_sub, opr1, opr2, out_ready,
                  output in_ready, out_valid, res, flags);
endinterface

// File: rtl/fp_addsub_pipe.sv
// Three-stage (align / add / normalise+round) FP add/sub with flush-to-zero,
// RNE rounding and a stallable valid/ready pipeline.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic            clk,
  input  logic            rst_n,
  fp_addsub_pipe_if.slave io
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SW     = MAN_W + 4;   // hidden + frac + guard/round/sticky
  localparam int STAGES = 3;
  localparam int LZW    = $clog2(SW + 1);
  localparam int XW     = EXP_W + 2;   // signed headroom for normalise
  localparam int MW     = MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             sub;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    ml;
    logic [SW-1:0]    ms;
    logic             spc;
    logic [W-1:0]     spc_res;
    logic [3:0]       spc_flg;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;
    logic             spc;
    logic [W-1:0]     spc_res;
    logic [3:0]       spc_flg;
  } s2_t;

  logic [STAGES:1] vld_q;
  logic [STAGES:0] vld_pipe;
  logic            adv;
  s1_t             s1_d, s1_q;
  s2_t             s2_d, s2_q;
  logic [W-1:0]    res_d, res_q;
  logic [3:0]      flg_d, flg_q;

  assign vld_pipe     = {vld_q, io.in_valid};
  assign adv          = ~vld_pipe[STAGES] | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = vld_pipe[STAGES];
  assign io.res       = res_q;
  assign io.flags     = flg_q;

  // ---- stage 1: classify, order by magnitude, align ----
  logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [EXP_W-1:0] ea, eb, el, es, d;
  logic [MAN_W-1:0] fa, fb, fl, fs;
  logic [W-2:0]     mag_a, mag_b;
  logic [SW-1:0]    ext_s, shifted, lost_mask;

  always_comb begin
    s1_d   = '0;
    sa     = io.opr1[W-1];
    sb     = io.opr2[W-1] ^ io.op_sub;
    ea     = io.opr1[W-2:MAN_W];
    eb     = io.opr2[W-2:MAN_W];
    fa     = io.opr1[MAN_W-1:0];
    fb     = io.opr2[MAN_W-1:0];
    a_zero = (ea == '0);
    b_zero = (eb == '0);
    a_inf  = (ea == EMAX) && (fa == '0);
    b_inf  = (eb == EMAX) && (fb == '0);
    a_nan  = (ea == EMAX) && (fa != '0);
    b_nan  = (eb == EMAX) && (fb != '0);
    // subnormals collapse to zero magnitude so they never win the swap
    mag_a  = a_zero ? '0 : {ea, fa};
    mag_b  = b_zero ? '0 : {eb, fb};
    swap   = mag_b > mag_a;
    {el, fl} = swap ? mag_b : mag_a;
    {es, fs} = swap ? mag_a : mag_b;
    ext_s     = (es == '0) ? '0 : {1'b1, fs, 3'b000};
    d         = el - es;
    shifted   = ext_s >> d;
    lost_mask = (SW'(1) << d) - SW'(1);
    s1_d.sign = swap ? sb : sa;
    s1_d.sub  = sa ^ sb;
    s1_d.exp  = el;
    s1_d.ml   = {1'b1, fl, 3'b000};
    s1_d.ms   = {shifted[SW-1:1], shifted[0] | (|(ext_s & lost_mask))};

    s1_d.spc = 1'b1;
    if (a_nan || b_nan)                     s1_d.spc_res = QNAN;
    else if (a_inf && b_inf && (sa != sb)) begin
      s1_d.spc_res = QNAN;
      s1_d.spc_flg = 4'b1000;
    end
    else if (a_inf)                         s1_d.spc_res = {sa, EMAX, {MAN_W{1'b0}}};
    else if (b_inf)                         s1_d.spc_res = {sb, EMAX, {MAN_W{1'b0}}};
    else if (a_zero && b_zero)              s1_d.spc_res = {sa & sb, {(W-1){1'b0}}};
    else                                    s1_d.spc     = 1'b0;
  end

  // ---- stage 2: magnitude add / subtract (ml >= ms always) ----
  always_comb begin
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.exp     = s1_q.exp;
    s2_d.spc     = s1_q.spc;
    s2_d.spc_res = s1_q.spc_res;
    s2_d.spc_flg = s1_q.spc_flg;
    s2_d.sum     = s1_q.sub ? ({1'b0, s1_q.ml} - {1'b0, s1_q.ms})
                            : ({1'b0, s1_q.ml} + {1'b0, s1_q.ms});
  end

  // ---- stage 3: normalise, round to nearest even, exceptions ----
  logic [LZW-1:0]   lz;
  logic [SW-1:0]    mn;
  logic [XW-1:0]    en, en_r;
  logic [MAN_W:0]   mant;
  logic [MW-1:0]    mr;
  logic [MAN_W-1:0] frac;
  logic             inx;

  always_comb begin
    lz = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (s2_q.sum[i]) lz = LZW'(SW - 1 - i);
    if (s2_q.sum[SW]) begin
      mn = {s2_q.sum[SW:2], |s2_q.sum[1:0]};
      en = {2'b00, s2_q.exp} + XW'(1);
    end else begin
      mn = s2_q.sum[SW-1:0] << lz;
      en = {2'b00, s2_q.exp} - XW'(lz);
    end
    mant = mn[SW-1:3];
    inx  = |mn[2:0];
    mr   = {1'b0, mant} + MW'(mn[2] & (mn[1] | mn[0] | mant[0]));
    if (mr[MW-1]) begin
      frac = mr[MAN_W:1];
      en_r = en + XW'(1);
    end else begin
      frac = mr[MAN_W-1:0];
      en_r = en;
    end

    res_d = {s2_q.sign, en_r[EXP_W-1:0], frac};
    flg_d = {3'b000, inx};
    if (s2_q.spc) begin
      res_d = s2_q.spc_res;
      flg_d = s2_q.spc_flg;
    end else if (s2_q.sum == '0) begin
      res_d = '0;
      flg_d = '0;
    end else if (en[XW-1] || (en == '0)) begin
      res_d = {s2_q.sign, {(W-1){1'b0}}};
      flg_d = 4'b0011;
    end else if (en_r >= {2'b00, EMAX}) begin
      res_d = {s2_q.sign, EMAX, {MAN_W{1'b0}}};
      flg_d = 4'b0101;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else if (adv) begin
      vld_q <= vld_pipe[STAGES-1:0];
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      res_q <= res_d;
      flg_q <= flg_d;
    end
  end
endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench: stimulus pushes expected {flags,res}; a negedge monitor
// compares every presented output against the queue head.
module tb_fp_addsub_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fp_addsub_pipe_if io ();
  fp_addsub_pipe dut (.clk(clk), .rst_n(rst_n), .io(io));

  logic [35:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int rdy_mode = 0;

  // Exact reference: operands as integers scaled by 2^149, summed exactly,
  // then rounded to single precision by definition.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    logic sa, sb, sr, inx;
    int ea, eb, p, ex;
    logic [22:0] fa, fb;
    logic [299:0] xa, xb, xs, m, rem, half;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    fa = a[22:0]; fb = b[22:0];
    if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0)) return {4'b0000, 32'h7FC00000};
    if (ea == 255 && eb == 255)
      return (sa != sb) ? {4'b1000, 32'h7FC00000} : {4'b0000, sa, 8'hFF, 23'h0};
    if (ea == 255) return {4'b0000, sa, 8'hFF, 23'h0};
    if (eb == 255) return {4'b0000, sb, 8'hFF, 23'h0};
    xa = (ea == 0) ? '0 : ({276'b0, 1'b1, fa} << (ea - 1));
    xb = (eb == 0) ? '0 : ({276'b0, 1'b1, fb} << (eb - 1));
    if (xa == 0 && xb == 0) return {4'b0000, sa & sb, 31'h0};
    if (sa == sb)      begin xs = xa + xb; sr = sa; end
    else if (xa >= xb) begin xs = xa - xb; sr = sa; end
    else               begin xs = xb - xa; sr = sb; end
    if (xs == 0) return 36'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (xs[i]) p = i;
    if (p <= 22) return {4'b0011, sr, 31'h0};
    ex   = p - 22;
    m    = xs >> (p - 23);
    rem  = xs & ((300'b1 << (p - 23)) - 300'b1);
    half = (p >= 24) ? (300'b1 << (p - 24)) : '0;
    inx  = (rem != 0);
    if (rem > half || (rem == half && rem != 0 && m[0])) m = m + 300'b1;
    if (m[24]) begin m = m >> 1; ex = ex + 1; end
    if (ex >= 255) return {4'b0101, sr, 8'hFF, 23'h0};
    return {3'b000, inx, sr, 8'(ex), m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input int ref_e);
    int r, e;
    logic [22:0] f;
    r = int'($urandom_range(0, 19));
    f = 23'($urandom);
    if (r == 0) e = 0;
    else if (r == 1) begin e = 255; if ($urandom % 2 == 0) f = '0; end
    else if (r < 10) begin
      e = ref_e + int'($urandom_range(0, 4)) - 2;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end
    else e = int'($urandom_range(1, 254));
    if (r == 2) f = '0;
    if (r == 3) f = '1;
    return {1'($urandom), 8'(e), f};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, want, $time);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [35:0] e);
    int n;
    io.in_valid = 1'b1; io.opr1 = a; io.opr2 = b; io.op_sub = s;
    n = 0;
    forever begin
      @(negedge clk);
      if (io.in_ready) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      total++; bad++;
      $display("FAIL accept_timeout a=%h b=%h", a, b);
    end else exp_q.push_back(e);
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic lat_check(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!io.out_valid && n < 10);
    chk(nm, 64'(n), 64'd3);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    rdy_mode = 0;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk(nm, 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // out_ready driver: always / 1,0,0,1 pattern / random 3-in-4
  initial begin
    logic [3:0] pat;
    int cyc;
    pat = 4'b1001;
    cyc = 0;
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      case (rdy_mode)
        0:       io.out_ready = 1'b1;
        1:       io.out_ready = pat[cyc % 4];
        default: io.out_ready = ($urandom % 4) != 0;
      endcase
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        chk("in_ready", 64'(io.in_ready), 64'(!io.out_valid || io.out_ready));
        if (io.out_valid) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out got=%h want=none", {io.flags, io.res});
          end else begin
            chk("result", 64'({io.flags, io.res}), 64'(exp_q[0]));
            if (io.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] da[14], db[14], fpi[9];
  logic        ds[14];
  logic [35:0] de[14];

  initial begin
    logic [31:0] a, b;
    logic s;
    da = '{32'h40400000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000,
           32'h3F800001, 32'h7F7FFFFF, 32'h7F800000, 32'h00000001, 32'h00800000,
           32'h00000000, 32'h7F800000, 32'h7FC00001, 32'h3F800000};
    db = '{32'h3F800000, 32'h3F800000, 32'h80000000, 32'h33800000, 32'h33C00000,
           32'h33800000, 32'h7F7FFFFF, 32'h7F800000, 32'h00000000, 32'h00800001,
           32'h80000000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
    ds = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
           1'b0, 1'b0, 1'b0, 1'b1};
    de = '{36'h0_40000000, 36'h0_00000000, 36'h0_80000000, 36'h1_3F800000,
           36'h1_3F800001, 36'h1_3F800002, 36'h5_7F800000, 36'h8_7FC00000,
           36'h0_00000000, 36'h3_80000000, 36'h0_00000000, 36'h0_7F800000,
           36'h0_7FC00000, 36'h0_BF000000};
    fpi = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

    rst_n = 1'b0;
    io.in_valid = 1'b0; io.op_sub = 1'b0; io.opr1 = '0; io.opr2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(io.out_valid), 64'd0);
    chk("rst_res", 64'(io.res), 64'd0);
    chk("rst_flags", 64'(io.flags), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    issue(32'h3F800000, 32'h40000000, 1'b0, 36'h0_40400000);
    lat_check("latency_basic");
    wait_drain("drain_basic");

    for (int i = 0; i < 14; i++) issue(da[i], db[i], ds[i], de[i]);
    wait_drain("drain_directed");

    rdy_mode = 1;
    for (int k = 0; k < 8; k++) issue(fpi[k], 32'h3F800000, 1'b0, {4'h0, fpi[k+1]});
    wait_drain("drain_backpressure");

    // reset with three operations in flight
    for (int k = 0; k < 3; k++) issue(fpi[k+2], fpi[k+1], 1'b0, 36'h0);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(io.out_valid), 64'd0);
    chk("midrst_res", 64'(io.res), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(32'h40400000, 32'h3F800000, 1'b0, 36'h0_40800000);
    lat_check("latency_after_rst");
    wait_drain("drain_after_rst");

    rdy_mode = 2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom % 4 == 0) begin @(posedge clk); #1; end
      a = rnd_fp(int'($urandom_range(1, 254)));
      b = rnd_fp(int'(a[30:23]));
      s = 1'($urandom);
      issue(a, b, s, model(a, b, s));
    end
    wait_drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
Pipelined, parametrised IEEE-754-style floating-point adder/subtractor for the FFT butterfly datapath. The operation is selectable per transaction: A+B or A−B, where subtraction is done by inverting the sign of B. It has three register stages (align, add, normalise/round) and a valid/ready handshake so the butterfly scheduler can stall it. Every cycle it accepts one operation and produces one result with exception flags.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored mantissa (fraction) width; word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  operands/op presented
in_ready  out  1  block accepts when in_valid & in_ready
op_sub  in  1  0: res=opr1+opr2, 1: res=opr1−opr2
opr1  in  W  operand A, {sign, exp, frac}
opr2  in  W  operand B
out_valid  out  1  res/flags valid
out_ready  in  1  consumer accepts when out_valid & out_ready
res  out  W  result
flags  out  4  {invalid, overflow, underflow, inexact}

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage-valid bits cleared, out_valid=0, res=0, flags=0. Reset mid-operation discards every in-flight operation; no result appears for them.
- Pipeline advance: adv = ~out_valid | out_ready. in_ready = adv, which is combinational from out_ready.
- When adv=1, all stages shift on the edge and bubbles propagate. When adv=0, all stage registers hold.
- Latency: 3 cycles from accept to out_valid with no stall. Throughput: 1 per cycle.
- res and flags stay stable while out_valid=1 & out_ready=0.
- Stage 1 (align):
  - effective B sign = sign(B) XOR op_sub.
  - Classify the operands.
  - Subnormal inputs (exp=0, frac≠0) are flushed to signed zero.
  - Swap so |A| ≥ |B| (compare exp, then frac).
  - Right-shift the smaller significand (hidden 1 restored) by the exponent difference. Keep guard and round bits, and OR all shifted-out bits into sticky.
  - A shift ≥ MAN_W+3 leaves only sticky.
- Stage 2 (add): effective add when the signs match, else subtract the smaller from the larger. The significand is MAN_W+4 bits wide plus a carry.
- Stage 3 (normalise/round):
  - Carry out: shift right 1, exp+1, and fold the shifted bit into sticky.
  - Otherwise left-shift by leading-zero count, with exp decremented accordingly.
  - Round to nearest, ties to even.
  - A rounding carry renormalises (exp+1).
- Special cases (priority order):
  - Either input NaN, or inf − inf as an effective subtraction → canonical quiet NaN {0, all-ones exp, 1, 0...}; invalid=1 only for inf−inf.
  - Either input inf → that inf, with its effective sign.
  - Exact zero result from nonzero operands → +0. (−0)+(−0) → −0; (+0)+(−0) → +0.
- Overflow: final exp ≥ all-ones → ±inf, overflow=1, inexact=1.
- Underflow: normalised exp ≤ 0 → signed zero (flush-to-zero), underflow=1, and inexact=1 if the true result is nonzero.
- inexact=1 whenever guard|round|sticky ≠ 0 before rounding.
- Simultaneous accept and output: allowed in the same cycle when out_ready=1.

Test Plan:
- Basic add: opr1=0x3F800000, opr2=0x40000000, op_sub=0, out_ready=1 → res=0x40400000 (3.0), flags=0, exactly 3 cycles after accept.
- Subtract and cancellation: 0x40400000 − 0x3F800000 → 0x40000000. 0x3F800000 − 0x3F800000 → 0x00000000, flags=0. 0x80000000 + 0x80000000 → 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (tie) → 0x3F800000, inexact=1.
  - 0x3F800000 + 0x33C00000 → 0x3F800001, inexact=1.
  - 0x3F800001 + 0x33800000 (tie, odd) → 0x3F800002.
- Exceptions:
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags=0b0101.
  - 0x7F800000 − 0x7F800000 → 0x7FC00000, flags=0b1000.
  - 0x00000001 + 0x00000000 → 0x00000000 (FTZ input).
  - 0x00800000 − 0x00800001 → 0x80000000, underflow=1.
- Backpressure: stream 8 back-to-back adds (k + 1.0 for k=0..7) with out_ready toggled 1,0,0,1,... → in_ready tracks out_ready while out_valid=1. All 8 results appear in order with no loss or duplication, and res is held constant during stalls.
- Reset mid-stream: assert rst_n=0 for 1 cycle with 3 operations in flight → out_valid=0 and res=0 the next cycle, no stale results afterwards. The first operation accepted after reset emerges 3 cycles later, correct.
